// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FFT datapath.
//   EW_DEF / FW_DEF : default exponent and stored-fraction widths (binary32-like)
//   EXP_MAX_DEF     : all-ones exponent code (infinity) of the default format
//   exp_bias()      : exponent bias 2^(ew-1)-1 for a given exponent width
//   fp_word_t       : packed {sign, exp, frac} word of the default format
package fp_pkg;

  localparam int unsigned EW_DEF      = 8;
  localparam int unsigned FW_DEF      = 23;
  localparam int unsigned EXP_MAX_DEF = (1 << EW_DEF) - 1;

  function automatic int unsigned exp_bias(input int unsigned ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  typedef struct packed {
    logic              sign;
    logic [EW_DEF-1:0] exp;
    logic [FW_DEF-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-one detector.
//   value : input vector, W bits
//   pos   : index of the most significant set bit (0 when value is zero)
//   zero  : value is all zeros
module fp_lzc #(
  parameter int unsigned W  = 27,
  parameter int unsigned PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  value,
  output logic [PW-1:0] pos,
  output logic          zero
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      if (value[i]) begin
        pos  = PW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Pipelined normalise / round / pack stage for the FFT floating-point datapath.
// Takes an unnormalised {sign, exponent, mantissa, sticky} triple and emits a packed
// {sign, exp, frac} word with overflow (saturate to infinity) and underflow (flush to
// zero) flags. Three internal stages plus an output register; a global stall holds the
// whole pipe while the output is valid and not accepted.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   in_sign, in_exp     : sign, EW+2-bit two's-complement biased exponent
//   in_man              : FW+4-bit mantissa {carry, hidden, fraction, guard, round}
//   in_sticky           : OR of bits already discarded upstream
//   out_valid/out_ready : output handshake
//   out_data            : {sign, exp[EW-1:0], frac[FW-1:0]}
//   out_ovf, out_unf    : saturated to infinity / flushed to zero
//
// Build option: define FP_NORM_PACK_ROUND_EN for round-to-nearest-even; otherwise the
// stage truncates. Latency and interface are the same in both builds.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned FW = FW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [EW+1:0]   in_exp,
  input  logic [FW+3:0]   in_man,
  input  logic            in_sticky,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+FW:0]  out_data,
  output logic            out_ovf,
  output logic            out_unf
);

  localparam int unsigned MW = FW + 4;        // input mantissa width
  localparam int unsigned XW = EW + 2;        // input exponent width
  localparam int unsigned XI = EW + 3;        // internal exponent width, headroom for +/- adjust
  localparam int unsigned SW = FW + 2;        // rounded significand incl. carry
  localparam int unsigned DW = 1 + EW + FW;
  localparam int unsigned PW = $clog2(MW);
  localparam logic [XI-1:0] EXP_TOP = XI'((1 << EW) - 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- S1: capture + LZC
  logic [PW-1:0] lz_pos;
  logic          lz_zero;

  fp_lzc #(
    .W  (MW),
    .PW (PW)
  ) u_lzc (
    .value (in_man),
    .pos   (lz_pos),
    .zero  (lz_zero)
  );

  logic          s1_valid, s1_sign, s1_sticky, s1_zero;
  logic [XW-1:0] s1_exp;
  logic [MW-1:0] s1_man;
  logic [PW-1:0] s1_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_exp    <= '0;
      s1_man    <= '0;
      s1_pos    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_sticky <= in_sticky;
      s1_zero   <= lz_zero;
      s1_exp    <= in_exp;
      s1_man    <= in_man;
      s1_pos    <= lz_pos;
    end
  end

  // ---------------------------------------------------------------- S2: normalise
  // After normalisation the carry bit is always clear, so only MW-1 bits are kept.
  logic [PW-1:0] shamt;
  logic [XI-1:0] exp_ext, norm_exp;
  logic [MW-2:0] norm_man;
  logic          norm_sticky;
  logic          shl_unused;

  always_comb begin
    exp_ext     = {s1_exp[XW-1], s1_exp};
    shamt       = PW'(FW + 2) - s1_pos;
    norm_sticky = s1_sticky;
    shl_unused  = 1'b0;
    if (s1_pos == PW'(FW + 3)) begin
      norm_man    = s1_man[MW-1:1];
      norm_exp    = exp_ext + XI'(1);
      norm_sticky = s1_sticky | s1_man[0];
    end else begin
      {shl_unused, norm_man} = s1_man << shamt;
      norm_exp               = exp_ext - XI'(shamt);
    end
  end

  logic          s2_valid, s2_sign, s2_sticky, s2_zero;
  logic [XI-1:0] s2_exp;
  logic [MW-2:0] s2_man;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sticky <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_man    <= '0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_sticky <= norm_sticky;
      s2_zero   <= s1_zero;
      s2_exp    <= norm_exp;
      s2_man    <= norm_man;
    end
  end

  // ---------------------------------------------------------------- S3: round + pack
  logic          lsb, g, r, inc, unused_rnd;
  logic          rnd_carry, rnd_unused_hidden;
  logic [FW-1:0] rnd_frac;
  logic [XI-1:0] fin_exp;
  logic [DW-1:0] pack_data;
  logic          pack_ovf, pack_unf;

  always_comb begin
    lsb = s2_man[2];
    g   = s2_man[1];
    r   = s2_man[0];
`ifdef FP_NORM_PACK_ROUND_EN
    inc        = g & (r | s2_sticky | lsb);
    unused_rnd = 1'b0;
`else
    inc        = 1'b0;
    unused_rnd = ^{lsb, g, r, s2_sticky};
`endif
    // A carry out of the hidden bit leaves the fraction all-zero, so only the exponent
    // needs the extra increment.
    {rnd_carry, rnd_unused_hidden, rnd_frac} = {1'b0, s2_man[MW-2:2]} + SW'(inc);
    fin_exp = s2_exp + XI'(rnd_carry);

    pack_data = '0;
    pack_ovf  = 1'b0;
    pack_unf  = 1'b0;
    if (s2_zero) begin
      pack_data = {s2_sign, {(DW-1){1'b0}}};
    end else if ($signed(fin_exp) >= $signed(EXP_TOP)) begin
      pack_data = {s2_sign, {EW{1'b1}}, {FW{1'b0}}};
      pack_ovf  = 1'b1;
    end else if (fin_exp[XI-1] || (fin_exp == '0)) begin
      pack_data = {s2_sign, {(DW-1){1'b0}}};
      pack_unf  = 1'b1;
    end else begin
      pack_data = {s2_sign, fin_exp[EW-1:0], rnd_frac};
    end
  end

  logic          s3_valid, s3_ovf, s3_unf;
  logic [DW-1:0] s3_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_ovf   <= 1'b0;
      s3_unf   <= 1'b0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      s3_data  <= pack_data;
      s3_ovf   <= pack_ovf;
      s3_unf   <= pack_unf;
    end
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (advance) begin
      out_valid <= s3_valid;
      out_data  <= s3_data;
      out_ovf   <= s3_ovf;
      out_unf   <= s3_unf;
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack (EW=8, FW=23): directed vector table, stall and
// reset sequences, and randomized traffic against an arithmetic reference model.
module tb_fp_norm_pack;

  localparam int EW = 8;
  localparam int FW = 23;
`ifdef FP_NORM_PACK_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, in_sign, in_sticky;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic        out_valid, out_ready, out_ovf, out_unf;
  logic [31:0] out_data;

  fp_norm_pack #(
    .EW (EW),
    .FW (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  bit sb_en = 1'b0;
  int delivered = 0;
  logic [33:0] sbq[$];  // {ovf, unf, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: normalise by repeated halving/doubling, then round and classify.
  function automatic logic [33:0] model(input logic sg, input logic [9:0] ex,
                                        input logic [26:0] mn, input logic st);
    longint e, m, q;
    bit sticky, g, r, lsb;
    e = longint'($signed(ex));
    m = longint'(mn);
    if (m == 0) return {2'b00, sg, 31'd0};
    sticky = st;
    while (m >= (longint'(1) << (FW + 3))) begin
      if (m % 2 == 1) sticky = 1'b1;
      m = m / 2;
      e++;
    end
    while (m < (longint'(1) << (FW + 2))) begin
      m = m * 2;
      e--;
    end
    q   = m / 4;
    g   = ((m % 4) / 2) == 1;
    r   = (m % 2) == 1;
    lsb = (q % 2) == 1;
    if (ROUND_EN && g && (r || sticky || lsb)) q++;
    if (q == (longint'(1) << (FW + 1))) begin
      q = q / 2;
      e++;
    end
    if (e >= (1 << EW) - 1) return {2'b10, sg, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, sg, 31'd0};
    return {2'b00, sg, e[7:0], q[22:0]};
  endfunction

  // Inputs are set after a negedge; this books the coming posedge and returns at the
  // next negedge.
  task automatic tick(output logic acc);
    #1;
    acc = in_valid && in_ready && !rst;
    if (!rst && sb_en) begin
      if (acc) sbq.push_back(model(in_sign, in_exp, in_man, in_sticky));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", out_data);
        end else begin
          check("sb_data", {out_ovf, out_unf, out_data}, sbq.pop_front());
          delivered++;
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] man;
    logic        sticky;
    logic [31:0] d_rne;
    logic [31:0] d_trn;
    logic [1:0]  flags;  // {ovf, unf}
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic acc;
    int lat, stall_left, stall_seen, sent, stray;

    vecs[0]  = '{1'b0, 10'd127, 27'(1 << 25), 1'b0, 32'h3F800000, 32'h3F800000, 2'b00};
    vecs[1]  = '{1'b0, 10'd127, 27'(3 << 25), 1'b0, 32'h40400000, 32'h40400000, 2'b00};
    vecs[2]  = '{1'b0, 10'd130, 27'(1 << 22), 1'b0, 32'h3F800000, 32'h3F800000, 2'b00};
    vecs[3]  = '{1'b0, 10'd127, 27'((1 << 25) | 2), 1'b0, 32'h3F800000, 32'h3F800000, 2'b00};
    vecs[4]  = '{1'b0, 10'd127, 27'((1 << 25) | 6), 1'b0, 32'h3F800002, 32'h3F800001, 2'b00};
    vecs[5]  = '{1'b0, 10'd127, 27'h3FFFFFF, 1'b0, 32'h40000000, 32'h3FFFFFFF, 2'b00};
    vecs[6]  = '{1'b0, 10'd254, 27'(3 << 25), 1'b0, 32'h7F800000, 32'h7F800000, 2'b10};
    vecs[7]  = '{1'b0, 10'd1, 27'(1 << 24), 1'b0, 32'h00000000, 32'h00000000, 2'b01};
    vecs[8]  = '{1'b1, 10'd127, 27'd0, 1'b0, 32'h80000000, 32'h80000000, 2'b00};
    vecs[9]  = '{1'b0, 10'd127, 27'((1 << 25) | 2), 1'b1, 32'h3F800001, 32'h3F800000, 2'b00};
    vecs[10] = '{1'b0, 10'd127, 27'((1 << 26) | 5), 1'b0, 32'h40000001, 32'h40000000, 2'b00};
    vecs[11] = '{1'b1, 10'h3FD, 27'(1 << 25), 1'b0, 32'h80000000, 32'h80000000, 2'b01};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_man = '0; in_sticky = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_unf", out_unf, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed vectors, one at a time.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_sign = vecs[i].sign; in_exp = vecs[i].exp;
      in_man = vecs[i].man; in_sticky = vecs[i].sticky;
      #1;
      check("vec_in_ready", in_ready, 1);
      tick(acc);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        tick(acc);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_data", i), out_data, ROUND_EN ? vecs[i].d_rne : vecs[i].d_trn);
      check($sformatf("vec%0d_flags", i), {out_ovf, out_unf}, vecs[i].flags);
      tick(acc);
    end

    // Stall: six items, output held off for five cycles after the first result.
    sb_en = 1'b1; sbq.delete(); delivered = 0; sent = 0;
    stall_left = -1; stall_seen = 0;
    for (int c = 0; c < 60 && delivered < 6; c++) begin
      in_valid = (sent < 6);
      in_sign = 1'b0; in_exp = 10'(120 + sent); in_man = 27'((1 << 25) | (sent << 3));
      in_sticky = 1'b0;
      if (stall_left < 0 && out_valid) stall_left = 5;
      out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        stall_seen++;
        check("stall_in_ready", in_ready, 0);
        if (sbq.size() > 0) check("stall_frozen", out_data, sbq[0][31:0]);
      end
      tick(acc);
      if (acc) sent++;
      if (stall_left > 0) stall_left--;
    end
    check("stall_cycles", stall_seen, 5);
    check("stall_delivered", delivered, 6);
    check("stall_queue_empty", sbq.size(), 0);

    // Reset mid-stream discards everything in flight.
    sb_en = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_exp = 10'(100 + k); in_man = 27'(1 << 25);
      tick(acc);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick(acc);
    check("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) stray++;
      tick(acc);
    end
    check("midrst_no_stray", stray, 0);

    // Randomized traffic with random backpressure.
    sb_en = 1'b1; sbq.delete(); delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      int lead;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sign   = 1'($urandom);
      in_exp    = 10'($urandom_range(0, 300)) - 10'd20;
      in_sticky = 1'($urandom);
      lead = $urandom_range(0, 27);
      if (lead == 27) in_man = '0;
      else in_man = 27'((32'd1 << lead) | ($urandom & ((32'd1 << lead) - 1)));
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() > 0; c++) tick(acc);
    check("random_drain_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
